rdb_lane_buffer: RTL and testbench
==================================

// Module: rdb_lane_buffer
// PURPOSE
// - Read data buffer for one direction (E/W/S/N; instantiated 4x). Consumes the 4 merged
//   per-hash lanes produced by the 2:1 channel select stage (vld + group_data_pld_t, no backpressure).
// - Buffers each lane in its own FIFO; round-robin drains one entry/cycle to the return path
//   via valid/ready. Returns one credit per drained entry so upstream never overruns a lane.
// PARAMETERS
// - LANE_NUM    4   lanes per direction (fixed by channel select stage; 2..8 legal)
// - DEPTH       4   entries per lane FIFO (power of 2, >=2)
// - CNT_W       $clog2(DEPTH+1)  occupancy counter width (derived, not overridable)
// PORTS
// - clk            in   1                    core clock
// - rst_n          in   1                    async reset, active low
// - in_vld         in   LANE_NUM             per-lane write strobe from channel select
// - in_pld         in   group_data_pld_t[LANE_NUM]  per-lane payload
// - out_vld        out  1                    head entry of granted lane available
// - out_pld        out  group_data_pld_t     payload of granted head
// - out_lane       out  $clog2(LANE_NUM)     lane index of out_pld
// - out_rdy        in   1                    downstream accept
// - credit_rtn     out  LANE_NUM             1-cycle pulse: one entry of lane i freed
// - lane_cnt       out  CNT_W*LANE_NUM       per-lane occupancy (debug/perf)
// - ovf_err        out  LANE_NUM             sticky: write to full lane was dropped
// BEHAVIOUR
// - Reset (async assert, sync release): all FIFO pointers/counts 0, out_vld=0, out_lane=0,
//   credit_rtn=0, ovf_err=0, RR pointer = lane 0. FIFO storage not reset.
// - Write: in_vld[i] pushes in_pld[i] into FIFO i at clk edge; all lanes may write same cycle.
// - Latency: entry written at edge t is eligible at out_* in cycle after t (no empty bypass).
// - Arbitration (comb): among non-empty lanes pick first at/after RR pointer (wrap LANE_NUM-1->0).
//   out_vld = any lane non-empty; out_pld/out_lane = granted head; out_lane=0 and out_pld
//   don't-care when out_vld=0.
// - Handshake: pop of granted lane iff out_vld & out_rdy. On pop RR pointer <= grant+1 (wrap);
//   without pop RR pointer holds, and out_pld/out_lane stay stable while out_vld & !out_rdy
//   (no new lane may win ahead of a stalled grant: grant is held until accepted).
// - Credit: credit_rtn[i] = pop of lane i that cycle (comb from handshake, at most one bit set).
// - Simultaneous push+pop same lane: count unchanged; legal even when full (pop frees slot first).
// - Full: push to full lane without same-cycle pop is dropped, FIFO unchanged, ovf_err[i]<=1
//   (sticky until reset). Protocol error; credits make it unreachable in correct systems.
// - Wrap-around: rd/wr pointers log2(DEPTH) bits, wrap naturally; count tracks full/empty.
// - Reset mid-operation: all buffered entries discarded; upstream credit counters also reset.
// - Assertions: onehot0(credit_rtn); out_pld stable under stall; no pop when empty.
// STRUCTURE
// - vector_cache_pkg: group_data_pld_t (existing), RDB_LANE_NUM=4, RDB_DEPTH=4 localparams.
// - Sub-module rdb_lane_fifo (DEPTH, payload type): push/pop/full/empty/cnt/ovf, LANE_NUM instances.
// - Top: generate loop of FIFOs, RR arbiter with hold-on-stall register, credit/ovf logic.
// TESTING
// - Single write lane 2 at t0, out_rdy=1 -> out_vld=1 at t0+1, out_lane=2, credit_rtn=4'b0100 same cycle.
// - All 4 lanes write once same cycle, out_rdy=1 -> drain order lanes 0,1,2,3 over 4 cycles, one credit each.
// - RR fairness: lanes 0 and 3 each hold 3 entries -> output lane order 0,3,0,3,0,3.
// - Stall: out_rdy=0 for 5 cycles with lane1 pending, lane0 written meanwhile -> out_lane stays 1,
//   out_pld stable, no credit; release -> lane1 then lane0.
// - Full: 5 writes to lane 0, out_rdy=0 -> lane_cnt[0]=4, ovf_err=4'b0001, 5th payload never output.
// - Full + push/pop same cycle lane 0 (DEPTH entries) -> no ovf, cnt stays 4; async reset mid-drain
//   -> out_vld=0, lane_cnt=0, ovf_err=0 immediately.

Source files
------------

// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and read-data-buffer sizing defaults.
package vector_cache_pkg;

  localparam int RDB_LANE_NUM = 4;
  localparam int RDB_DEPTH    = 4;

  typedef struct packed {
    logic [3:0]  grp_id;
    logic [27:0] data;
  } group_data_pld_t;

  // Round-robin successor with wrap for arbitrary (non power-of-2) lane counts.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rdb_lane_fifo.sv
// Single-lane FIFO: registered output (no empty bypass), sticky overflow on dropped push.
module rdb_lane_fifo
  import vector_cache_pkg::*;
#(
  parameter int  DEPTH = RDB_DEPTH,
  parameter type pld_t = group_data_pld_t,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  pld_t             din,
  input  logic             pop,
  output pld_t             dout,
  output logic             empty,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push;
  pld_t          mem [DEPTH];

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  // A same-cycle pop frees the slot, so a full lane still accepts the push.
  assign do_push = push & (~full | pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (push & ~do_push) ovf <= 1'b1;
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);

endmodule

// File: rtl/rdb_lane_buffer.sv
// Per-direction read data buffer: LANE_NUM lane FIFOs drained round-robin, one credit per pop.
module rdb_lane_buffer
  import vector_cache_pkg::*;
#(
  parameter int  LANE_NUM = RDB_LANE_NUM,
  parameter int  DEPTH    = RDB_DEPTH,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int LW       = $clog2(LANE_NUM)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic            [LANE_NUM-1:0]     in_vld,
  input  group_data_pld_t [LANE_NUM-1:0]     in_pld,
  output logic                               out_vld,
  output group_data_pld_t                    out_pld,
  output logic            [LW-1:0]           out_lane,
  input  logic                               out_rdy,
  output logic            [LANE_NUM-1:0]     credit_rtn,
  output logic [LANE_NUM-1:0][CNT_W-1:0]     lane_cnt,
  output logic            [LANE_NUM-1:0]     ovf_err
);

  logic            [LANE_NUM-1:0] lane_empty, lane_pop;
  group_data_pld_t [LANE_NUM-1:0] lane_head;
  logic [LW-1:0] rr_ptr, rr_lane, hold_lane, grant;
  logic          rr_found, hold_vld, pop;

  generate
    for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
      rdb_lane_fifo #(
        .DEPTH (DEPTH),
        .pld_t (group_data_pld_t)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_vld[i]),
        .din   (in_pld[i]),
        .pop   (lane_pop[i]),
        .dout  (lane_head[i]),
        .empty (lane_empty[i]),
        .cnt   (lane_cnt[i]),
        .ovf   (ovf_err[i])
      );
    end
  endgenerate

  always_comb begin
    rr_lane  = rr_ptr;
    rr_found = 1'b0;
    for (int k = 0; k < LANE_NUM; k++) begin
      if (!rr_found && !lane_empty[(int'(rr_ptr) + k) % LANE_NUM]) begin
        rr_found = 1'b1;
        rr_lane  = LW'((int'(rr_ptr) + k) % LANE_NUM);
      end
    end
  end

  // A stalled grant is pinned so a lane filling ahead of it cannot steal the slot.
  assign grant    = hold_vld ? hold_lane : rr_lane;
  assign out_vld  = ~&lane_empty;
  assign out_lane = out_vld ? grant : '0;
  assign out_pld  = lane_head[grant];
  assign pop      = out_vld & out_rdy;
  assign lane_pop = LANE_NUM'(pop) << grant;
  assign credit_rtn = lane_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      hold_vld  <= 1'b0;
      hold_lane <= '0;
    end else if (pop) begin
      rr_ptr   <= LW'(rr_next(int'(grant), LANE_NUM));
      hold_vld <= 1'b0;
    end else if (out_vld) begin
      hold_vld  <= 1'b1;
      hold_lane <= grant;
    end
  end

  a_credit_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(credit_rtn));
  a_stall_stable:  assert property (@(posedge clk) disable iff (!rst_n)
                     out_vld && !out_rdy |=> out_vld && $stable(out_pld) && $stable(out_lane));

endmodule

// File: tb/tb_rdb_lane_buffer.sv
// Scoreboard bench: per-lane expected queues fed by the stimulus, checked at every negedge.
module tb_rdb_lane_buffer;
  import vector_cache_pkg::*;

  localparam int L     = RDB_LANE_NUM;
  localparam int D     = RDB_DEPTH;
  localparam int CNT_W = $clog2(D + 1);
  localparam int LW    = $clog2(L);

  logic                           clk, rst_n;
  logic            [L-1:0]        in_vld;
  group_data_pld_t [L-1:0]        in_pld;
  logic                           out_vld, out_rdy;
  group_data_pld_t                out_pld;
  logic [LW-1:0]                  out_lane;
  logic [L-1:0]                   credit_rtn, ovf_err;
  logic [L-1:0][CNT_W-1:0]        lane_cnt;

  rdb_lane_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld     (in_vld),
    .in_pld     (in_pld),
    .out_vld    (out_vld),
    .out_pld    (out_pld),
    .out_lane   (out_lane),
    .out_rdy    (out_rdy),
    .credit_rtn (credit_rtn),
    .lane_cnt   (lane_cnt),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents per lane, fair-rotation pointer, pinned grant while stalled.
  group_data_pld_t mq [L][$];
  int              m_rr    = 0;
  bit              m_hold  = 0;
  int              m_hlane = 0;
  logic [L-1:0]    m_ovf   = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < L; i++) mq[i].delete();
    m_rr = 0; m_hold = 0; m_hlane = 0; m_ovf = '0;
  endtask

  // Called at posedge+1: drive one cycle of inputs, then record accepted writes.
  task automatic step(input logic [L-1:0] v, input logic rdy);
    group_data_pld_t p [L];
    for (int i = 0; i < L; i++) begin
      p[i] = group_data_pld_t'($urandom());
      in_pld[i] = p[i];
    end
    in_vld  = v;
    out_rdy = rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < L; i++)
      if (v[i]) begin
        if (mq[i].size() < D) mq[i].push_back(p[i]);
        else m_ovf[i] = 1'b1;
      end
    in_vld = '0;
  endtask

  task automatic do_reset();
    in_vld  = '0;
    out_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_lane_cnt", 64'(lane_cnt), 64'd0);
    check("rst_ovf_err", 64'(ovf_err), 64'd0);
    check("rst_credit", 64'(credit_rtn), 64'd0);
    check("rst_out_lane", 64'(out_lane), 64'd0);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon
    int           g;
    bit           any;
    logic [L-1:0] ecr;
    if (rst_n) begin
      any = 0; g = 0;
      if (m_hold) begin
        any = 1; g = m_hlane;
      end else begin
        for (int k = 0; k < L; k++)
          if (!any && mq[(m_rr + k) % L].size() > 0) begin
            any = 1; g = (m_rr + k) % L;
          end
      end
      check("out_vld", 64'(out_vld), 64'(any));
      if (any) begin
        check("out_lane", 64'(out_lane), 64'(g));
        check("out_pld", 64'(out_pld), 64'(mq[g][0]));
      end else begin
        check("out_lane_idle", 64'(out_lane), 64'd0);
      end
      ecr = (any && out_rdy) ? (L'(1) << g) : '0;
      check("credit_rtn", 64'(credit_rtn), 64'(ecr));
      for (int i = 0; i < L; i++) check("lane_cnt", 64'(lane_cnt[i]), 64'(mq[i].size()));
      check("ovf_err", 64'(ovf_err), 64'(m_ovf));
      if (any && out_rdy) begin
        void'(mq[g].pop_front());
        m_rr   = (g + 1) % L;
        m_hold = 0;
      end else if (any) begin
        m_hold  = 1;
        m_hlane = g;
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    in_vld  = '0;
    in_pld  = '0;
    out_rdy = 1'b0;
    #1;
    check("init_out_vld", 64'(out_vld), 64'd0);
    check("init_lane_cnt", 64'(lane_cnt), 64'd0);
    check("init_ovf_err", 64'(ovf_err), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write to lane 2.
    step(4'b0100, 1'b1);
    repeat (2) step('0, 1'b1);

    // All lanes at once from a fresh pointer: drain 0,1,2,3.
    do_reset();
    step(4'b1111, 1'b1);
    repeat (5) step('0, 1'b1);

    // Fairness: lanes 0 and 3 with three entries each.
    do_reset();
    repeat (3) step(4'b1001, 1'b0);
    repeat (8) step('0, 1'b1);

    // Overflow: fifth write to lane 0 is dropped.
    do_reset();
    repeat (5) step(4'b0001, 1'b0);
    step('0, 1'b0);
    check("full_cnt0", 64'(lane_cnt[0]), 64'd4);
    check("full_ovf", 64'(ovf_err), 64'b0001);
    repeat (6) step('0, 1'b1);

    // Full lane with simultaneous push and pop, then reset mid-drain.
    do_reset();
    repeat (4) step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    check("pushpop_cnt0", 64'(lane_cnt[0]), 64'd4);
    check("pushpop_ovf", 64'(ovf_err), 64'd0);
    repeat (2) step('0, 1'b1);
    do_reset();

    // Stall with lane 1 granted while lane 0 fills behind it.
    step(4'b0010, 1'b0);
    step(4'b0001, 1'b0);
    repeat (4) step('0, 1'b0);
    repeat (3) step('0, 1'b1);

    // Random traffic, including overflow and a mid-run reset.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      step(L'($urandom()), $urandom_range(0, 3) != 0);
    end
    repeat (40) step('0, 1'b1);
    check("final_drained", 64'(out_vld), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
